// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and single-outstanding load returns into one register-file write port.
module regfile_writeback (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_dest_i,
  input  logic [31:0] alu_data_i,
  input  logic        load_issue_i,
  input  logic [4:0]  load_dest_i,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  load_offset_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] old_data_i,
  output logic        write_enable_o,
  output logic [4:0]  write_addr_o,
  output logic [31:0] write_data_o,
  output logic        busy_o,
  output logic        stall_o
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE_LOAD} state_t;
  state_t state, state_n;
  logic [4:0] pend_dest;
  logic [2:0] pend_type;
  logic [1:0] pend_off;
  logic [31:0] mem_q, sh, load_data;
  logic [7:0] b;
  logic [15:0] h;
  logic wl, wm, stall, accept;
  // The memory word is held raw; LWL/LWR merge with old_data_i only once the write cycle reads the register file.
  always_comb begin
    sh = mem_q >> {pend_off, 3'b000};
    b = sh[7:0];
    h = pend_off[1] ? mem_q[31:16] : mem_q[15:0];
    load_data = pend_type == 3'd0 ? {{24{b[7]}}, b} :
                pend_type == 3'd1 ? {24'd0, b} :
                pend_type == 3'd2 ? {{16{h[15]}}, h} :
                pend_type == 3'd3 ? {16'd0, h} :
                pend_type == 3'd5 ? (mem_q << {~pend_off, 3'b000}) | (old_data_i & ~(32'hFFFF_FFFF << {~pend_off, 3'b000})) :
                pend_type == 3'd6 ? (mem_q >> {pend_off, 3'b000}) | (old_data_i & ~(32'hFFFF_FFFF >> {pend_off, 3'b000})) :
                mem_q;
  end
  always_comb begin
    wl = state == WRITE_LOAD;
    wm = state == WAIT_MEM;
    stall = (wl && alu_valid_i) ||
            (wm && (load_issue_i || (alu_valid_i && alu_dest_i == pend_dest && pend_dest != 5'd0)));
    state_n = state == IDLE ? (load_issue_i ? WAIT_MEM : IDLE) :
              wm ? (mem_valid_i ? WRITE_LOAD : WAIT_MEM) :
              (load_issue_i ? WAIT_MEM : IDLE);
    accept = (state == IDLE || wl) && load_issue_i;
    write_addr_o = reset_i ? 5'd0 : wl ? pend_dest : alu_dest_i;
    write_data_o = reset_i ? 32'd0 : wl ? load_data : alu_data_i;
    write_enable_o = !reset_i && write_addr_o != 5'd0 && (wl || (alu_valid_i && !stall));
    stall_o = !reset_i && stall;
    busy_o = !reset_i && (wm || wl);
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
      pend_dest <= '0;
      pend_type <= '0;
      pend_off <= '0;
      mem_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        pend_dest <= load_dest_i;
        pend_type <= load_type_i;
        pend_off <= load_offset_i;
      end
      if (wm && mem_valid_i) mem_q <= mem_data_i;
    end
  end
endmodule
